// File: rtl/vga_fb_reader.sv
// vga_fb_reader: 640x480 VGA timing generator that scans a 160x120 RGB332
// frame buffer, repeating every stored pixel 4x horizontally and vertically.
// Pipeline: stage 0 = counters, stage 1 = registered RAM address/strobe,
// stage 2 = colour built from the RAM word plus syncs/visible delayed to match.
module vga_fb_reader #(
    parameter int H_VIS = 640,
    parameter int H_FP  = 16,
    parameter int H_SW  = 96,
    parameter int H_BP  = 48,
    parameter int V_VIS = 480,
    parameter int V_FP  = 10,
    parameter int V_SW  = 2,
    parameter int V_BP  = 33,
    parameter int FB_W  = 160,
    parameter int FB_H  = 120
) (
    input  logic        Clk,
    input  logic        Rst_n,
    output logic [14:0] Addr,
    output logic        Rd_en,
    input  logic [7:0]  Datos,
    output logic        Hsync,
    output logic        Vsync,
    output logic [3:0]  R,
    output logic [3:0]  G,
    output logic [3:0]  B,
    output logic        Active,
    output logic        Frame_start
);

    localparam int H_TOT = H_VIS + H_FP + H_SW + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SW + V_BP;
    localparam int HW    = $clog2(H_TOT);
    localparam int VW    = $clog2(V_TOT);

    localparam logic [HW-1:0] HC_LAST  = HW'(H_TOT - 1);
    localparam logic [HW-1:0] HC_VIS   = HW'(H_VIS);
    localparam logic [HW-1:0] HS_BEG   = HW'(H_VIS + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_VIS + H_FP + H_SW - 1);
    localparam logic [HW-1:0] HC_ONE   = {{(HW-1){1'b0}}, 1'b1};
    localparam logic [VW-1:0] VC_LAST  = VW'(V_TOT - 1);
    localparam logic [VW-1:0] VC_VIS   = VW'(V_VIS);
    localparam logic [VW-1:0] VS_BEG   = VW'(V_VIS + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_VIS + V_FP + V_SW - 1);
    localparam logic [VW-1:0] VC_ONE   = {{(VW-1){1'b0}}, 1'b1};
    localparam logic [14:0]   ROW_STEP = 15'(FB_W);
    localparam logic [14:0]   ADDR_MAX = 15'(FB_W * FB_H - 1);

    // RGB332 -> 4:4:4 by replicating the top bits into the low bits
    function automatic logic [11:0] rgb332_expand(input logic [7:0] px);
        return {px[7:5], px[7], px[4:2], px[4], px[1:0], px[1:0]};
    endfunction

    // stage 0 counters and row base
    logic [HW-1:0] hc_q, hc_d;
    logic [VW-1:0] vc_q, vc_d;
    logic [14:0]   row_base_q, row_base_d;
    // stage 1
    logic [14:0]   addr_q, addr_d;
    logic          rd_en_q, rd_en_d;
    logic          fs_q, fs_d;
    logic          hs1_q, hs1_d, vs1_q, vs1_d;
    // intermediate stage (RAM access cycle)
    logic          vis2_q, vis2_d, hs2_q, hs2_d, vs2_q, vs2_d;
    // stage 2 outputs
    logic          hsync_q, hsync_d, vsync_q, vsync_d, active_q, active_d;
    logic [3:0]    r_q, r_d, g_q, g_d, b_q, b_d;

    logic          vis_s, hs_s, vs_s, fs_s;
    logic [14:0]   addr_sum_s;
    logic [11:0]   rgb_s;

    // Next-state logic for counters, row base and every pipeline stage
    always_comb begin
        hc_d       = hc_q;
        vc_d       = vc_q;
        row_base_d = row_base_q;

        // Row base tracks (vc>>2)*FB_W incrementally, no multiplier needed
        if (hc_q == HC_LAST) begin
            hc_d = '0;
            if (vc_q == VC_LAST) begin
                vc_d       = '0;
                row_base_d = 15'd0;
            end else begin
                vc_d = vc_q + VC_ONE;
                if ((vc_d[1:0] == 2'b00) && (vc_d < VC_VIS)) begin
                    row_base_d = row_base_q + ROW_STEP;
                end else begin
                    row_base_d = row_base_q;
                end
            end
        end else begin
            hc_d = hc_q + HC_ONE;
        end

        vis_s      = (hc_q < HC_VIS) && (vc_q < VC_VIS);
        hs_s       = !((hc_q >= HS_BEG) && (hc_q <= HS_END));
        vs_s       = !((vc_q >= VS_BEG) && (vc_q <= VS_END));
        fs_s       = (hc_q == '0) && (vc_q == '0);
        addr_sum_s = row_base_q + 15'(hc_q >> 2'd2);

        // Address holds outside the visible area; saturate as a safety net
        addr_d = addr_q;
        if (vis_s) begin
            if (addr_sum_s > ADDR_MAX) begin
                addr_d = ADDR_MAX;
            end else begin
                addr_d = addr_sum_s;
            end
        end else begin
            addr_d = addr_q;
        end
        rd_en_d = vis_s;
        fs_d    = fs_s;
        hs1_d   = hs_s;
        vs1_d   = vs_s;

        vis2_d  = rd_en_q;
        hs2_d   = hs1_q;
        vs2_d   = vs1_q;

        // Datos for the pixel in vis2 is on the bus now
        rgb_s    = rgb332_expand(Datos);
        active_d = vis2_q;
        hsync_d  = hs2_q;
        vsync_d  = vs2_q;
        if (vis2_q) begin
            r_d = rgb_s[11:8];
            g_d = rgb_s[7:4];
            b_d = rgb_s[3:0];
        end else begin
            r_d = 4'h0;
            g_d = 4'h0;
            b_d = 4'h0;
        end
    end

    // State registers with asynchronous active-low clear
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            hc_q       <= '0;
            vc_q       <= '0;
            row_base_q <= 15'd0;
            addr_q     <= 15'd0;
            rd_en_q    <= 1'b0;
            fs_q       <= 1'b0;
            hs1_q      <= 1'b1;
            vs1_q      <= 1'b1;
            vis2_q     <= 1'b0;
            hs2_q      <= 1'b1;
            vs2_q      <= 1'b1;
            hsync_q    <= 1'b1;
            vsync_q    <= 1'b1;
            active_q   <= 1'b0;
            r_q        <= 4'h0;
            g_q        <= 4'h0;
            b_q        <= 4'h0;
        end else begin
            hc_q       <= hc_d;
            vc_q       <= vc_d;
            row_base_q <= row_base_d;
            addr_q     <= addr_d;
            rd_en_q    <= rd_en_d;
            fs_q       <= fs_d;
            hs1_q      <= hs1_d;
            vs1_q      <= vs1_d;
            vis2_q     <= vis2_d;
            hs2_q      <= hs2_d;
            vs2_q      <= vs2_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            active_q   <= active_d;
            r_q        <= r_d;
            g_q        <= g_d;
            b_q        <= b_d;
        end
    end

    assign Addr        = addr_q;
    assign Rd_en       = rd_en_q;
    assign Frame_start = fs_q;
    assign Hsync       = hsync_q;
    assign Vsync       = vsync_q;
    assign Active      = active_q;
    assign R           = r_q;
    assign G           = g_q;
    assign B           = b_q;

endmodule

// File: doc/vga_fb_reader.md
VGA_FB_READER -- requirements
Module: vga_fb_reader

Interface
REQ-001 SHALL have parameter H_VIS, default 640: visible pixels per line.
REQ-002 SHALL have parameter H_FP / H_SW / H_BP, defaults 16 / 96 / 48: horizontal front porch, sync width and back porch in clocks.
REQ-003 SHALL have parameter V_VIS, default 480: visible lines.
REQ-004 SHALL have parameter V_FP / V_SW / V_BP, defaults 10 / 2 / 33: vertical front porch, sync width and back porch in lines.
REQ-005 SHALL have parameter FB_W / FB_H, defaults 160 / 120: frame-buffer width and height in pixels (scale factor 4).
REQ-006 SHALL have port Clk, input, 1: 25 MHz pixel clock; all logic on its rising edge.
REQ-007 SHALL have port Rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port Addr, output, 15: frame-buffer read address.
REQ-009 SHALL have port Rd_en, output, 1: read strobe.
REQ-010 SHALL have port Datos, input, 8: RGB332 pixel returned by the synchronous RAM one clock after Addr/Rd_en.
REQ-011 SHALL have port Hsync and port Vsync, outputs, 1 each: active-low VGA syncs.
REQ-012 SHALL have ports R, G and B, outputs, 4 each: VGA colour.
REQ-013 SHALL have port Active, output, 1: high when R/G/B carry a visible pixel.
REQ-014 SHALL have port Frame_start, output, 1: one-clock pulse at the start of each frame.

Function
REQ-015 SHALL count hc from 0 to H_TOT-1 (800), wrapping to 0, and count vc from 0 to V_TOT-1 (525), advancing only when hc wraps.
REQ-016 SHALL treat stage-0 visible as hc<H_VIS and vc<V_VIS.
REQ-017 SHALL drive stage-0 hsync low for hc in [656,751] and stage-0 vsync low for vc in [490,491], using default parameters.
REQ-018 SHALL register, on each rising edge of Clk, Addr=(vc>>2)*FB_W+(hc>>2) and Rd_en=visible (stage 1); outside the visible region Addr holds its last value and Rd_en=0.
REQ-019 SHALL compute Addr without a hardware multiplier: a row-base accumulator adds FB_W once every 4 visible lines and clears at vc=0.
REQ-020 SHALL keep Addr at or below FB_W*FB_H-1 (19199) at all times.
REQ-021 SHALL delay hsync, vsync and visible by exactly 2 clocks so that Hsync/Vsync/Active align with the Datos-derived colour (stage 2).
REQ-022 SHALL set colour at stage 2 as R={Datos[7:5],Datos[7]}, G={Datos[4:2],Datos[4]} and B={Datos[1:0],Datos[1:0]} when delayed visible=1, else R=G=B=0.
REQ-023 SHALL repeat each frame-buffer pixel on 4 consecutive clocks and each frame-buffer row on 4 consecutive lines.
REQ-024 SHALL pulse Frame_start for exactly one clock when stage-0 hc=0 and vc=0.
REQ-025 SHALL have no state beyond the counters, the row-base accumulator and the 2-stage pipeline; Datos is not checked for validity.

Reset
REQ-026 SHALL, while Rst_n=0, force hc=0, vc=0, row base=0, Addr=0, Rd_en=0, Hsync=1, Vsync=1, Active=0, R=G=B=0, Frame_start=0, with every pipeline stage cleared.
REQ-027 SHALL, on Rst_n assertion mid-frame, apply REQ-026 immediately without waiting for Clk.
REQ-028 SHALL, after reset release, start timing at hc=0, vc=0: Frame_start pulses on the first rising edge of Clk, and the first Rd_en=1 occurs on that same edge with Addr=0.

Verification
REQ-029 SHALL cover a full frame with default parameters -> Hsync low for 96 clocks per 800-clock line, Vsync low for 2 lines per 525-line frame, and 307200 Active clocks.
REQ-030 SHALL cover a RAM model with Datos=Addr[7:0] -> at line 0, hc 0..7 gives Addr 0,0,0,0,1,1,1,1; at line 4, hc 0 gives Addr=160; at line 479, hc 639 gives Addr=19199.
REQ-031 SHALL cover Datos=8'hE3 during visible -> R=4'hF, G=4'h0, B=4'hF, with Active=1 exactly 2 clocks after the corresponding Rd_en.
REQ-032 SHALL cover Datos=8'hFF during blanking -> R=G=B=0 and Active=0.
REQ-033 SHALL cover Rst_n pulsed low at vc=200, hc=300 -> outputs at reset values asynchronously; after release, Frame_start=1 on the next edge and the timing restarts at (0,0).
REQ-034 SHALL cover two consecutive frames -> Frame_start pulses exactly 420000 clocks apart, and the Addr sequence is identical in both frames.
